// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: bus/field widths,
// instruction field bit positions, FSM state encoding and the NOP word.
// TIMEOUT_CYCLES is consumed only when FETCH_TIMEOUT_EN is defined.
package instr_fetch_unit_pkg;
    localparam int INSTR_WIDTH     = 16;
    localparam int ADDR_WIDTH      = 16;
    localparam int OPCODE_WIDTH    = 4;
    localparam int REG_ADDR_WIDTH  = 3;
    localparam int IMMEDIATE_WIDTH = 6;
    localparam int TIMEOUT_CYCLES  = 15;

    // Field LSB positions inside the IR
    localparam int OPCODE_LSB = 12;
    localparam int RS_LSB     = 9;
    localparam int RT_LSB     = 6;
    localparam int RD_LSB     = 3;
    localparam int IMM_LSB    = 0;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_LATCHED = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// fetch_timeout_ctr: counts WAIT cycles without an ack and flags expiry.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart the count (asserted on the edge that enters WAIT)
//   active      fetch unit is in WAIT this cycle
//   ack         memory ack this cycle (an ack always beats expiry)
//   expired     the current cycle is the TIMEOUT_CYCLES-th WAIT cycle with no ack
// Used only when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr
    import instr_fetch_unit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (clear)            cnt <= '0;
        else if (active && !ack)   cnt <= cnt + CW'(1);
    end

    // cnt holds the number of ack-less WAIT cycles already elapsed, so the
    // cycle seeing TIMEOUT_CYCLES-1 is the last one allowed.
    assign expired = active && !ack && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction word per fetch_start over a
// req/ack memory handshake, holds it in the IR and slices out the fields.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_start, pc_in         fetch request from the control FSM and its PC
//   mem_rd_req, mem_addr       registered read request / address to memory
//   mem_rd_ack, mem_rdata      memory response
//   fetch_busy                 1 while waiting for memory
//   ir_valid                   IR holds a freshly fetched word
//   opcode, rs, rt, rd, imm    combinational slices of the IR (imm -> sign_extend)
//   pc_next                    latched pc_in + 1
//   bus_err                    1-cycle pulse on fetch timeout
// Optional feature: define FETCH_TIMEOUT_EN to abandon a fetch after
// TIMEOUT_CYCLES ack-less WAIT cycles; otherwise WAIT never times out and
// bus_err is tied low.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_start,
    input  logic [ADDR_WIDTH-1:0]      pc_in,
    output logic                       mem_rd_req,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic                       mem_rd_ack,
    input  logic [INSTR_WIDTH-1:0]     mem_rdata,
    output logic                       fetch_busy,
    output logic                       ir_valid,
    output logic [OPCODE_WIDTH-1:0]    opcode,
    output logic [REG_ADDR_WIDTH-1:0]  rs,
    output logic [REG_ADDR_WIDTH-1:0]  rt,
    output logic [REG_ADDR_WIDTH-1:0]  rd,
    output logic [IMMEDIATE_WIDTH-1:0] imm,
    output logic [ADDR_WIDTH-1:0]      pc_next,
    output logic                       bus_err
);
    fetch_state_e           state, state_nxt;
    logic [INSTR_WIDTH-1:0] ir;
    logic                   accept;   // fetch_start taken (ignored in WAIT)
    logic                   latch;    // ack taken (only honoured in WAIT)
    logic                   timeout;

    assign accept     = fetch_start && (state != FETCH_WAIT);
    assign latch      = (state == FETCH_WAIT) && mem_rd_ack;
    assign fetch_busy = (state == FETCH_WAIT);

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .active  (state == FETCH_WAIT),
        .ack     (mem_rd_ack),
        .expired (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus_err <= 1'b0;
        else        bus_err <= timeout;
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE, FETCH_LATCHED: if (fetch_start) state_nxt = FETCH_WAIT;
            FETCH_WAIT: begin
                if (mem_rd_ack)   state_nxt = FETCH_LATCHED;
                else if (timeout) state_nxt = FETCH_IDLE;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_req <= 1'b0;
            mem_addr   <= '0;
            pc_next    <= '0;
            ir         <= NOP_INSTR;
            ir_valid   <= 1'b0;
        end else if (accept) begin
            mem_rd_req <= 1'b1;
            mem_addr   <= pc_in;
            pc_next    <= pc_in + ADDR_WIDTH'(1);  // wraps at 2^ADDR_WIDTH
            ir_valid   <= 1'b0;
        end else if (latch) begin
            mem_rd_req <= 1'b0;
            ir         <= mem_rdata;
            ir_valid   <= 1'b1;
        end else if (timeout) begin
            // IR keeps the previous word; ir_valid is already 0 in WAIT
            mem_rd_req <= 1'b0;
        end
    end

    assign opcode = ir[OPCODE_LSB +: OPCODE_WIDTH];
    assign rs     = ir[RS_LSB     +: REG_ADDR_WIDTH];
    assign rt     = ir[RT_LSB     +: REG_ADDR_WIDTH];
    assign rd     = ir[RD_LSB     +: REG_ADDR_WIDTH];
    assign imm    = ir[IMM_LSB    +: IMMEDIATE_WIDTH];
endmodule
